// File: rtl/strobe_frame_sched.sv
// Per-frame strobe scheduler: sequences a lit frame and a dark frame, then
// hands the pair to the detection engine and reports one result per pair.
module strobe_frame_sched #(
  parameter int TIMEOUT = 50000,
  parameter int TO_W    = 16
) (
  input  logic       pclk,
  input  logic       resetn,
  input  logic       i_frame_start,
  input  logic       i_frame_end,
  input  logic       i_en_strobe,
  output logic       o_led_on,
  output logic       o_frame_lit,
  output logic       o_det_req,
  input  logic       i_det_ack,
  input  logic       i_det_done,
  input  logic       i_det_result,
  output logic       o_obj_det,
  output logic       o_obj_det_trig,
  output logic       o_timeout,
  output logic [7:0] o_drop_cnt
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SKIP,
    LIT,
    DARK_WAIT,
    DARK,
    REQ,
    BUSY,
    REPORT
  } state_t;

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            result_q, result_d;
  logic            led_on_q, led_on_d;
  logic            frame_lit_q, frame_lit_d;
  logic            det_req_q, det_req_d;
  logic            obj_det_q, obj_det_d;
  logic            trig_q, trig_d;
  logic            timeout_q, timeout_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic            engine_busy;

  assign engine_busy = (state_q == REQ) || (state_q == BUSY) || (state_q == REPORT);

  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    result_d   = result_q;
    obj_det_d  = 1'b0;
    trig_d     = 1'b0;
    timeout_d  = 1'b0;
    drop_cnt_d = drop_cnt_q;

    case (state_q)
      IDLE: begin
        if (i_frame_start) begin
          state_d = i_en_strobe ? LIT : SKIP;
        end
      end
      SKIP: begin
        if (i_frame_end) begin
          trig_d    = 1'b1;
          obj_det_d = 1'b0;
          state_d   = IDLE;
        end
      end
      LIT: begin
        if (i_frame_end) begin
          state_d = DARK_WAIT;
        end
      end
      DARK_WAIT: begin
        if (i_frame_start) begin
          state_d = DARK;
        end
      end
      DARK: begin
        if (i_frame_end) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (i_det_ack) begin
          to_cnt_d = '0;
          if (i_det_done) begin
            result_d = i_det_result;
            state_d  = REPORT;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        // A result arriving on the last allowed cycle still counts as valid.
        if (i_det_done) begin
          result_d = i_det_result;
          state_d  = REPORT;
        end else if (to_cnt_q == TO_LAST) begin
          result_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = REPORT;
        end
      end
      REPORT: begin
        trig_d    = 1'b1;
        obj_det_d = result_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (i_frame_start && engine_busy && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end

    led_on_d    = (state_d == LIT);
    frame_lit_d = (state_d == LIT);
    det_req_d   = (state_d == REQ);
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      to_cnt_q    <= '0;
      result_q    <= 1'b0;
      led_on_q    <= 1'b0;
      frame_lit_q <= 1'b0;
      det_req_q   <= 1'b0;
      obj_det_q   <= 1'b0;
      trig_q      <= 1'b0;
      timeout_q   <= 1'b0;
      drop_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      result_q    <= result_d;
      led_on_q    <= led_on_d;
      frame_lit_q <= frame_lit_d;
      det_req_q   <= det_req_d;
      obj_det_q   <= obj_det_d;
      trig_q      <= trig_d;
      timeout_q   <= timeout_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign o_led_on       = led_on_q;
  assign o_frame_lit    = frame_lit_q;
  assign o_det_req      = det_req_q;
  assign o_obj_det      = obj_det_q;
  assign o_obj_det_trig = trig_q;
  assign o_timeout      = timeout_q;
  assign o_drop_cnt     = drop_cnt_q;

endmodule
